// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU widths and arbiter FSM state encodings
package alu_arbiter_pkg;
    localparam int ALU_W     = 32;
    localparam int ALU_OUT_W = 33;
    localparam int OPC_W     = 3;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first request after last wins (one-hot and index)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        gnt = '0;
        idx = '0;
        // walk from farthest to nearest so the nearest valid requester wins
        for (int k = N; k > 0; k--) begin
            if (req[(int'(last) + k) % N]) begin
                gnt = '0;
                gnt[(int'(last) + k) % N] = 1'b1;
                idx = IW'((int'(last) + k) % N);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NREQ requesters; ALU_ARB_PRIO0_EN gives requester 0 strict priority
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPC_W*NREQ-1:0] req_opcode,
    input  logic [ALU_W*NREQ-1:0] req_a,
    input  logic [ALU_W*NREQ-1:0] req_b,
    output logic                  alu_en,
    output logic [OPC_W-1:0]      alu_opcode,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    input  logic [ALU_OUT_W-1:0]  alu_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [ALU_OUT_W-1:0]  resp_data
);
    state_t          state, state_n;
    logic [IDW-1:0]  last_grant, pick_idx, gidx;
    logic [NREQ-1:0] pick_gnt, gnt;
    logic            upd, accept;

    rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

`ifdef ALU_ARB_PRIO0_EN
    assign gnt  = req_valid[0] ? NREQ'(1) : pick_gnt;
    assign gidx = req_valid[0] ? '0 : pick_idx;
    assign upd  = !req_valid[0];
`else
    assign gnt  = pick_gnt;
    assign gidx = pick_idx;
    assign upd  = 1'b1;
`endif

    always_comb begin
        accept    = (state == IDLE) && (|req_valid);
        req_ready = (state == IDLE) ? gnt : '0;
        alu_en    = (state == EXEC);
        state_n   = (state == IDLE) ? (accept ? EXEC : IDLE) :
                    (state == EXEC) ? RESP :
                    (state == RESP) ? (resp_ready ? IDLE : RESP) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                alu_opcode <= req_opcode[OPC_W*gidx +: OPC_W];
                alu_a      <= req_a[ALU_W*gidx +: ALU_W];
                alu_b      <= req_b[ALU_W*gidx +: ALU_W];
                resp_id    <= gidx;
                if (upd) last_grant <= gidx;
            end
            if (state == EXEC) begin
                resp_data  <= alu_out;
                resp_valid <= 1'b1;
            end
            if (state == RESP && resp_ready) resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [11:0] req_opcode;
    logic [127:0] req_a, req_b;
    logic        alu_en;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_a, alu_b;
    logic [32:0] alu_out;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [32:0] resp_data;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_opcode, alu_a, alu_b);

    typedef struct {
        logic [3:0]  valid;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  id;
        logic [32:0] data;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_opcode[3*i +: 3] = (i == w) ? op : 3'd7;
            req_a[32*i +: 32]    = (i == w) ? a : (32'hdead0000 | 32'(i));
            req_b[32*i +: 32]    = (i == w) ? b : (32'hbeef0000 | 32'(i));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b1;
        drive(4'b0000, 0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        bit ok = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, 3'd0, 32'h0000abcd, 32'h0000def2, 2'd0, 33'h0_00018abf};
        tbl[1] = '{4'b1111, 3'd1, 32'd10,       32'd3,        2'd1, 33'h0_00000007};
        tbl[2] = '{4'b0001, 3'd2, 32'hf0f0f0f0, 32'hff00ff00, 2'd0, 33'h0_f000f000};
        tbl[3] = '{4'b1001, 3'd3, 32'h0f000000, 32'h000000f0, 2'd3, 33'h0_0f0000f0};
        tbl[4] = '{4'b0110, 3'd4, 32'hffff0000, 32'hff00ff00, 2'd1, 33'h0_00ffff00};
        tbl[5] = '{4'b0101, 3'd0, 32'hffffffff, 32'h00000001, 2'd2, 33'h1_00000000};
        tbl[6] = '{4'b0011, 3'd1, 32'h00000000, 32'h00000001, 2'd0, 33'h1_ffffffff};
        tbl[7] = '{4'b1000, 3'd0, 32'h7fffffff, 32'h00000001, 2'd3, 33'h0_80000000};

        do_reset();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_en", 64'(alu_en), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_op", 64'(alu_opcode), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);

`ifndef ALU_ARB_PRIO0_EN
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            drive(tbl[v].valid, int'(tbl[v].id), tbl[v].op, tbl[v].a, tbl[v].b);
            #1;
            chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(4'b0001 << tbl[v].id));
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            chk($sformatf("v%0d_alu_en", v), 64'(alu_en), 64'd1);
            chk($sformatf("v%0d_alu_a", v), 64'(alu_a), 64'(tbl[v].a));
            chk($sformatf("v%0d_alu_op", v), 64'(alu_opcode), 64'(tbl[v].op));
            chk($sformatf("v%0d_exec_ready", v), 64'(req_ready), 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_resp_valid", v), 64'(resp_valid), 64'd1);
            chk($sformatf("v%0d_resp_id", v), 64'(resp_id), 64'(tbl[v].id));
            chk($sformatf("v%0d_resp_data", v), 64'(resp_data), 64'(tbl[v].data));
            chk($sformatf("v%0d_resp_alu_en", v), 64'(alu_en), 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_resp_done", v), 64'(resp_valid), 64'd0);
        end

        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_opcode[3*i +: 3] = 3'd0;
            req_a[32*i +: 32]    = 32'(i) << 8;
            req_b[32*i +: 32]    = 32'd1;
        end
        for (int k = 0; k < 6; k++) begin
            wait_resp("rr");
            chk($sformatf("rr%0d_id", k), 64'(resp_id), 64'(k % 4));
            chk($sformatf("rr%0d_data", k), 64'(resp_data), 64'((k % 4) * 256 + 1));
            @(negedge clk);
        end
`endif

        do_reset();
        resp_ready = 1'b0;
        drive(4'b0001, 0, 3'd0, 32'd5, 32'd6);
        wait_resp("bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'd1);
            chk($sformatf("bp%0d_data", c), 64'(resp_data), 64'd11);
            chk($sformatf("bp%0d_id", c), 64'(resp_id), 64'd0);
            chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("bp_reaccept_en", 64'(alu_en), 64'd1);
        repeat (3) @(negedge clk);

        do_reset();
        drive(4'b0001, 0, 3'd0, 32'd1, 32'd1);
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        drive(4'b0010, 1, 3'd0, 32'd1, 32'd2);
        @(negedge clk);
        #1;
        chk("mid_exec_en", 64'(alu_en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_alu_en", 64'(alu_en), 64'd0);
        chk("mid_alu_a", 64'(alu_a), 64'd0);
        rst = 1'b0;
        drive(4'b1111, 0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("mid_next_grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);

`ifdef ALU_ARB_PRIO0_EN
        do_reset();
        drive(4'b0101, 0, 3'd0, 32'd4, 32'd4);
        for (int k = 0; k < 3; k++) begin
            wait_resp("pr");
            chk($sformatf("pr%0d_id", k), 64'(resp_id), 64'd0);
            chk($sformatf("pr%0d_data", k), 64'(resp_data), 64'd8);
            if (k == 2) req_valid = 4'b0100;
            @(negedge clk);
        end
        wait_resp("pr_drop");
        chk("pr_drop_id", 64'(resp_id), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
